wait_cmd_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the wait-event TB stage. It buffers wait commands in a small FIFO: each command carries a signal index, an edge type and a timeout. It issues the commands one at a time on the wait-event control lines (`en_wait_event`, `wait_en`, `sel_wtr_wtf`, `max_timeout`) and tracks `wait_done` with its own cycle guard. One status record is reported per command, so a scenario driver can queue several waits without polling.

---
 rtl/wait_cmd_pkg.sv | 25 ++
 rtl/wait_cmd_fifo.sv | 56 +++++
 rtl/wait_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_wait_cmd_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wait_cmd_pkg.sv
// Shared types for the wait-command sequencer: command record, FSM states,
// edge-select constants and the index range check.
package wait_cmd_pkg;

   localparam logic WTR = 1'b0;
   localparam logic WTF = 1'b1;

   typedef struct packed {
      logic [7:0]  sel;
      logic        edge_sel;
      logic [31:0] timeout;
   } wait_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      REPORT
   } seq_state_e;

   function automatic logic sel_in_range(input logic [7:0] sel, input int size);
      return int'({24'd0, sel}) < size;
   endfunction

endpackage

// File: rtl/wait_cmd_fifo.sv
// Small synchronous FIFO of wait commands; the head is visible combinationally
// so the sequencer can pop and register a command in the same cycle.
module wait_cmd_fifo
   import wait_cmd_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  wait_cmd_t     din,
   input  logic          pop,
   output wait_cmd_t     dout,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   wait_cmd_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/wait_cmd_sequencer.sv
// Queues wait commands and issues them one at a time to the wait-event stage,
// reporting one status per command. Optional counters under WAIT_CMD_SEQ_STATS_EN.
module wait_cmd_sequencer
   import wait_cmd_pkg::*;
#(
   parameter  int WAIT_SIZE  = 5,
   parameter  int FIFO_DEPTH = 4,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [7:0]    i_cmd_sel,
   input  logic          i_cmd_edge,
   input  logic [31:0]   i_cmd_timeout,
   output logic          o_en_wait_event,
   output logic [31:0]   o_wait_en,
   output logic          o_sel_wtr_wtf,
   output logic [31:0]   o_max_timeout,
   input  logic          i_wait_done,
   output logic          o_sts_valid,
   output logic          o_sts_timeout,
   output logic          o_sts_err,
   output logic [31:0]   o_sts_cycles,
   output logic          o_busy,
   output logic [LW-1:0] o_fifo_level,
   output logic [15:0]   o_cnt_done,
   output logic [15:0]   o_cnt_timeout
);

   seq_state_e  state;
   wait_cmd_t   push_cmd;
   wait_cmd_t   head;
   logic        full;
   logic        empty;
   logic        pop;
   logic [31:0] cnt;
   logic [31:0] cnt_next;

   assign push_cmd = '{sel: i_cmd_sel, edge_sel: i_cmd_edge, timeout: i_cmd_timeout};
   assign o_cmd_ready = !full;
   assign pop = (state == IDLE) && !empty;
   assign cnt_next = (cnt == '1) ? cnt : cnt + 32'd1;

   wait_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (i_cmd_valid && o_cmd_ready),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (head),
      .level (o_fifo_level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         o_en_wait_event <= 1'b0;
         o_wait_en       <= '0;
         o_sel_wtr_wtf   <= WTR;
         o_max_timeout   <= '0;
         cnt             <= '0;
         o_sts_valid     <= 1'b0;
         o_sts_timeout   <= 1'b0;
         o_sts_err       <= 1'b0;
         o_sts_cycles    <= '0;
         o_busy          <= 1'b0;
      end else begin
         o_en_wait_event <= 1'b0;
         o_sts_valid     <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  o_busy <= 1'b1;
                  if (sel_in_range(head.sel, WAIT_SIZE)) begin
                     o_wait_en       <= {24'd0, head.sel};
                     o_sel_wtr_wtf   <= head.edge_sel;
                     o_max_timeout   <= head.timeout;
                     o_en_wait_event <= 1'b1;
                     state           <= ISSUE;
                  end else begin
                     o_sts_valid   <= 1'b1;
                     o_sts_err     <= 1'b1;
                     o_sts_timeout <= 1'b0;
                     o_sts_cycles  <= '0;
                     state         <= REPORT;
                  end
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt_next;
               // Done is checked first so it wins over a same-cycle guard expiry.
               if (i_wait_done) begin
                  o_sts_valid   <= 1'b1;
                  o_sts_err     <= 1'b0;
                  o_sts_timeout <= 1'b0;
                  o_sts_cycles  <= cnt_next;
                  state         <= REPORT;
               end else if (o_max_timeout != '0 && cnt_next == o_max_timeout) begin
                  o_sts_valid   <= 1'b1;
                  o_sts_err     <= 1'b0;
                  o_sts_timeout <= 1'b1;
                  o_sts_cycles  <= cnt_next;
                  state         <= REPORT;
               end
            end
            REPORT: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WAIT_CMD_SEQ_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_cnt_done    <= '0;
         o_cnt_timeout <= '0;
      end else if (o_sts_valid) begin
         if (o_sts_timeout) begin
            if (o_cnt_timeout != 16'hFFFF) o_cnt_timeout <= o_cnt_timeout + 16'd1;
         end else begin
            if (o_cnt_done != 16'hFFFF) o_cnt_done <= o_cnt_done + 16'd1;
         end
      end
   end
`else
   assign o_cnt_done    = '0;
   assign o_cnt_timeout = '0;
`endif

endmodule

// File: tb/tb_wait_cmd_sequencer.sv
// Randomized and directed bench for wait_cmd_sequencer against a command-level
// scoreboard; counter checks follow WAIT_CMD_SEQ_STATS_EN.
module tb_wait_cmd_sequencer;
   import wait_cmd_pkg::*;

   localparam int WAIT_SIZE  = 5;
   localparam int FIFO_DEPTH = 4;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef WAIT_CMD_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic          o_cmd_ready;
   logic [7:0]    i_cmd_sel = '0;
   logic          i_cmd_edge = 1'b0;
   logic [31:0]   i_cmd_timeout = '0;
   logic          o_en_wait_event;
   logic [31:0]   o_wait_en;
   logic          o_sel_wtr_wtf;
   logic [31:0]   o_max_timeout;
   logic          i_wait_done = 1'b0;
   logic          o_sts_valid;
   logic          o_sts_timeout;
   logic          o_sts_err;
   logic [31:0]   o_sts_cycles;
   logic          o_busy;
   logic [LW-1:0] o_fifo_level;
   logic [15:0]   o_cnt_done;
   logic [15:0]   o_cnt_timeout;

   always #5 clk = ~clk;

   wait_cmd_sequencer #(.WAIT_SIZE(WAIT_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .i_cmd_valid     (i_cmd_valid),
      .o_cmd_ready     (o_cmd_ready),
      .i_cmd_sel       (i_cmd_sel),
      .i_cmd_edge      (i_cmd_edge),
      .i_cmd_timeout   (i_cmd_timeout),
      .o_en_wait_event (o_en_wait_event),
      .o_wait_en       (o_wait_en),
      .o_sel_wtr_wtf   (o_sel_wtr_wtf),
      .o_max_timeout   (o_max_timeout),
      .i_wait_done     (i_wait_done),
      .o_sts_valid     (o_sts_valid),
      .o_sts_timeout   (o_sts_timeout),
      .o_sts_err       (o_sts_err),
      .o_sts_cycles    (o_sts_cycles),
      .o_busy          (o_busy),
      .o_fifo_level    (o_fifo_level),
      .o_cnt_done      (o_cnt_done),
      .o_cnt_timeout   (o_cnt_timeout)
   );

   // done_at: WAIT cycle in which the bench raises done, 0 = never.
   typedef struct {
      logic [7:0]  sel;
      logic        edge_sel;
      logic [31:0] timeout;
      int          done_at;
   } tcmd_t;

   tcmd_t stim_q[$];
   tcmd_t exp_q[$];
   tcmd_t lc;
   tcmd_t cur;
   int    errors = 0;
   int    checks = 0;
   bit    in_wait = 1'b0;
   int    wcyc = 0;
   int    end_cyc = 0;
   bit    exp_to = 1'b0;
   int    m_done = 0;
   int    m_to = 0;
   int    push_pct = 100;
   int    quiet = 0;
   bit    abort = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_en"},      o_en_wait_event, 0);
      check_val({tag, "_wait_en"}, o_wait_en, 0);
      check_val({tag, "_edge"},    o_sel_wtr_wtf, 0);
      check_val({tag, "_maxto"},   o_max_timeout, 0);
      check_val({tag, "_sts"},     {o_sts_valid, o_sts_timeout, o_sts_err}, 0);
      check_val({tag, "_cycles"},  o_sts_cycles, 0);
      check_val({tag, "_busy"},    o_busy, 0);
      check_val({tag, "_level"},   o_fifo_level, 0);
      check_val({tag, "_ready"},   o_cmd_ready, 1);
      check_val({tag, "_cnt"},     {o_cnt_done, o_cnt_timeout}, 0);
   endtask

   task automatic add_cmd(input int sel, input logic edge_sel, input int timeout, input int done_at);
      tcmd_t c;
      c.sel = 8'(sel);
      c.edge_sel = edge_sel;
      c.timeout = 32'(timeout);
      c.done_at = done_at;
      stim_q.push_back(c);
   endtask

   // One clock: sample outputs, update the scoreboard, drive the next inputs.
   task automatic step();
      int lvl;
      bit reported;
      reported = 1'b0;
      @(posedge clk);
      #1;
      check_val("cnt_done", o_cnt_done, STATS ? 32'(m_done) : 32'd0);
      check_val("cnt_timeout", o_cnt_timeout, STATS ? 32'(m_to) : 32'd0);
      if (in_wait) wcyc++;

      if (o_sts_valid) begin
         quiet = 0;
         reported = 1'b1;
         if (exp_q.size() == 0) begin
            check_val("sts_spurious", o_sts_valid, 0);
         end else begin
            cur = exp_q.pop_front();
            if (!sel_in_range(cur.sel, WAIT_SIZE)) begin
               check_val("err_launched", in_wait, 0);
               check_val("err_flag", o_sts_err, 1);
               check_val("err_cycles", o_sts_cycles, 0);
               check_val("err_timeout", o_sts_timeout, 0);
               m_done++;
            end else begin
               check_val("sts_unlaunched", in_wait, 1);
               check_val("sts_latency", wcyc, end_cyc + 1);
               check_val("sts_err", o_sts_err, 0);
               check_val("sts_timeout", o_sts_timeout, exp_to);
               check_val("sts_cycles", o_sts_cycles, end_cyc);
               if (exp_to) m_to++; else m_done++;
               $display("cmd sel=%0d edge=%0d to=%0d done_at=%0d -> cycles=%0d timeout=%0d",
                        cur.sel, cur.edge_sel, cur.timeout, cur.done_at, o_sts_cycles, o_sts_timeout);
            end
            in_wait = 1'b0;
         end
      end else if (in_wait && wcyc == end_cyc + 1) begin
         check_val("sts_missing", o_sts_valid, 1);
         void'(exp_q.pop_front());
         in_wait = 1'b0;
      end

      if (o_en_wait_event) begin
         quiet = 0;
         check_val("en_while_busy", in_wait, 0);
         if (exp_q.size() == 0) begin
            check_val("en_spurious", o_en_wait_event, 0);
         end else begin
            lc = exp_q[0];
            check_val("en_sel_range", sel_in_range(lc.sel, WAIT_SIZE), 1);
            check_val("wait_en", o_wait_en, {24'd0, lc.sel});
            check_val("sel_wtr_wtf", o_sel_wtr_wtf, lc.edge_sel);
            check_val("max_timeout", o_max_timeout, lc.timeout);
            in_wait = 1'b1;
            wcyc = 0;
            if (lc.done_at != 0 && (lc.timeout == 0 || lc.done_at <= int'(lc.timeout))) begin
               end_cyc = lc.done_at;
               exp_to = 1'b0;
            end else begin
               end_cyc = int'(lc.timeout);
               exp_to = 1'b1;
            end
         end
      end else if (in_wait) begin
         check_val("hold_wait_en", o_wait_en, {24'd0, lc.sel});
         check_val("hold_max_timeout", o_max_timeout, lc.timeout);
      end

      lvl = exp_q.size() - (in_wait ? 1 : 0);
      check_val("fifo_level", o_fifo_level, lvl);
      check_val("cmd_ready", o_cmd_ready, lvl < FIFO_DEPTH);
      check_val("busy", o_busy, in_wait || reported);

      if (!o_sts_valid && !o_en_wait_event && exp_q.size() != 0) begin
         quiet++;
         if (quiet > 400) begin
            check_val("stall", quiet, 0);
            abort = 1'b1;
         end
      end

      if (in_wait && wcyc > 0) i_wait_done = (wcyc == lc.done_at);
      else                     i_wait_done = 1'($urandom_range(0, 1));

      if (stim_q.size() != 0 && int'($urandom_range(0, 99)) < push_pct) begin
         i_cmd_valid   = 1'b1;
         i_cmd_sel     = stim_q[0].sel;
         i_cmd_edge    = stim_q[0].edge_sel;
         i_cmd_timeout = stim_q[0].timeout;
         if (o_cmd_ready) exp_q.push_back(stim_q.pop_front());
      end else begin
         i_cmd_valid   = 1'b0;
         i_cmd_sel     = 8'($urandom);
         i_cmd_edge    = 1'($urandom);
         i_cmd_timeout = $urandom;
      end
   endtask

   task automatic run_drained(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (abort) break;
         if (stim_q.size() == 0 && exp_q.size() == 0 && !in_wait) break;
         step();
      end
      if (!abort && (stim_q.size() != 0 || exp_q.size() != 0)) begin
         check_val("drain_budget", exp_q.size() + stim_q.size(), 0);
         abort = 1'b1;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Directed cases: plain done, guard expiry, bad index, no guard, done wins tie.
      push_pct = 100;
      add_cmd(2, WTR, 100, 5);
      add_cmd(3, WTF, 10, 0);
      add_cmd(7, WTR, 5, 1);
      add_cmd(1, WTR, 0, 2);
      add_cmd(4, WTF, 3, 3);
      run_drained(400);

      // Stalled first wait fills the FIFO; statuses must come out in push order.
      add_cmd(0, WTR, 0, 30);
      add_cmd(1, WTF, 4, 2);
      add_cmd(2, WTR, 6, 0);
      add_cmd(3, WTF, 0, 1);
      add_cmd(200, WTR, 2, 2);
      add_cmd(1, WTF, 9, 4);
      run_drained(400);

      // Random traffic.
      push_pct = 40;
      for (int i = 0; i < 120; i++) begin
         int sel, to, d;
         sel = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WAIT_SIZE, 255))
                                           : int'($urandom_range(0, WAIT_SIZE - 1));
         to  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
         d   = (to == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(0, 25));
         add_cmd(sel, 1'($urandom), to, d);
      end
      run_drained(8000);

      // Reset in the middle of a wait with two commands queued.
      if (!abort) begin
         push_pct = 100;
         add_cmd(2, WTF, 0, 100);
         add_cmd(1, WTR, 5, 1);
         add_cmd(3, WTF, 5, 1);
         for (int n = 0; n < 60; n++) begin
            if (in_wait && wcyc >= 3 && exp_q.size() == 3) break;
            step();
         end
         check_val("rst_setup_queued", exp_q.size(), 3);
         #2;
         rst = 1'b1;
         #1;
         check_zero("midrst");
         stim_q.delete();
         exp_q.delete();
         in_wait = 1'b0;
         m_done = 0;
         m_to = 0;
         i_cmd_valid = 1'b0;
         i_wait_done = 1'b0;
         repeat (2) @(negedge clk);
         rst = 1'b0;
         repeat (10) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
